// File: rtl/sram_ctrl.sv
// sram_ctrl: single-word valid/ready front end for a 256K x 16 asynchronous SRAM.
// Every SRAM-side signal and every response signal is driven straight from a register.
module sram_ctrl #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int RD_CYC = 2,
    parameter int WR_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    localparam int LANE    = DATA_W / 2;
    localparam int CNT_MAX = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    if (RD_CYC < 1) begin : g_bad_rd_cyc
        $error("sram_ctrl: RD_CYC must be >= 1");
    end
    if (WR_CYC < 1) begin : g_bad_wr_cyc
        $error("sram_ctrl: WR_CYC must be >= 1");
    end
    if ((DATA_W % 2) != 0) begin : g_bad_data_w
        $error("sram_ctrl: DATA_W must be even (two byte lanes)");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_END,
        S_TURN,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD
    } state_t;

    state_t            r_state, w_state;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_ready, w_ready;
    logic              r_rsp_valid, w_rsp_valid;
    logic [DATA_W-1:0] r_rdata, w_rdata;
    logic [ADDR_W-1:0] r_a, w_a;
    logic [DATA_W-1:0] r_dq_o, w_dq_o;
    logic              r_dq_oe, w_dq_oe;
    logic              r_ce_n, w_ce_n;
    logic              r_oe_n, w_oe_n;
    logic              r_we_n, w_we_n;
    logic              r_lb_n, w_lb_n;
    logic              r_ub_n, w_ub_n;
    logic [DATA_W-1:0] w_lane_mask;

    assign w_lane_mask = {{LANE{~r_ub_n}}, {LANE{~r_lb_n}}};

    // Next-state and next-output logic; outputs are computed here and registered below
    // so no input reaches a pad without passing through a flop.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_rsp_valid = 1'b0;
        w_rdata     = r_rdata;
        w_a         = r_a;
        w_dq_o      = r_dq_o;
        w_dq_oe     = r_dq_oe;
        w_ce_n      = r_ce_n;
        w_oe_n      = r_oe_n;
        w_we_n      = r_we_n;
        w_lb_n      = r_lb_n;
        w_ub_n      = r_ub_n;

        case (r_state)
            S_IDLE: begin
                if (req_valid && r_ready) begin
                    w_a    = req_addr;
                    w_dq_o = req_wdata;
                    w_lb_n = ~req_be[0];
                    w_ub_n = ~req_be[1];
                    w_ce_n = 1'b0;
                    w_cnt  = CNT_W'(1);
                    if (req_we) begin
                        w_state = S_WR_SETUP;
                        w_dq_oe = 1'b1;
                        w_we_n  = 1'b1;
                    end else begin
                        w_state = S_RD;
                        w_oe_n  = 1'b0;
                    end
                end
            end
            S_RD: begin
                if (r_cnt == CNT_W'(RD_CYC)) begin
                    w_state     = S_RD_END;
                    w_ce_n      = 1'b1;
                    w_oe_n      = 1'b1;
                    w_rsp_valid = 1'b1;
                    w_rdata     = sram_dq_i & w_lane_mask;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_RD_END: begin
                w_state = S_TURN;
            end
            S_TURN: begin
                w_state = S_IDLE;
            end
            S_WR_SETUP: begin
                w_state = S_WR_PULSE;
                w_we_n  = 1'b0;
                w_cnt   = CNT_W'(1);
            end
            S_WR_PULSE: begin
                if (r_cnt == CNT_W'(WR_CYC)) begin
                    w_state = S_WR_HOLD;
                    w_we_n  = 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_WR_HOLD: begin
                w_state = S_IDLE;
                w_ce_n  = 1'b1;
                w_dq_oe = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_ready = (w_state == S_IDLE);
    end

    // State and output registers with synchronous reset to the idle/deasserted values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_a         <= '0;
            r_dq_o      <= '0;
            r_dq_oe     <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_ub_n      <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_ready     <= w_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rdata     <= w_rdata;
            r_a         <= w_a;
            r_dq_o      <= w_dq_o;
            r_dq_oe     <= w_dq_oe;
            r_ce_n      <= w_ce_n;
            r_oe_n      <= w_oe_n;
            r_we_n      <= w_we_n;
            r_lb_n      <= w_lb_n;
            r_ub_n      <= w_ub_n;
        end
    end

    assign req_ready  = r_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rdata;
    assign sram_a     = r_a;
    assign sram_dq_o  = r_dq_o;
    assign sram_dq_oe = r_dq_oe;
    assign sram_ce_n  = r_ce_n;
    assign sram_oe_n  = r_oe_n;
    assign sram_we_n  = r_we_n;
    assign sram_lb_n  = r_lb_n;
    assign sram_ub_n  = r_ub_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Testbench for sram_ctrl: behavioural SRAM on the pad side, a reference memory and
// response queue fed at request acceptance, and a negedge monitor for strobe timing.
`timescale 1ns/1ps
module tb_sram_ctrl;

    localparam int AW  = 18;
    localparam int DW  = 16;
    localparam int RDC = 2;
    localparam int WRC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [1:0]    req_be = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_dq_o;
    logic          sram_dq_oe;
    logic [DW-1:0] sram_dq_i;
    logic          sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_CYC(RDC), .WR_CYC(WRC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural asynchronous SRAM; disabled lanes float to a recognisable junk value.
    logic [DW-1:0] dev_mem [0:(1<<AW)-1];
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n)
        ? {(sram_ub_n ? 8'hEE : dev_mem[sram_a][15:8]), (sram_lb_n ? 8'hEE : dev_mem[sram_a][7:0])}
        : 16'hDEAD;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_lb_n) dev_mem[sram_a][7:0]  <= sram_dq_o[7:0];
            if (!sram_ub_n) dev_mem[sram_a][15:8] <= sram_dq_o[15:8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model and scoreboard.
    typedef struct { logic [DW-1:0] d; int due; } rsp_t;
    typedef struct { logic we; logic [AW-1:0] a; logic [DW-1:0] d; logic [1:0] be; } req_t;

    logic [DW-1:0] mdl [0:(1<<AW)-1];
    rsp_t q_rsp[$];
    req_t cur;
    int   ready_due = -1;
    int   ce_cnt = 0, we_cnt = 0, oe_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            q_rsp.delete();
            ready_due = -1;
            ce_cnt = 0; we_cnt = 0; oe_cnt = 0;
        end else begin
            chk("oe_while_dq_oe", {31'd0, !sram_oe_n && sram_dq_oe}, 32'd0);
            chk("we_while_oe",    {31'd0, !sram_we_n && !sram_oe_n}, 32'd0);

            if (rsp_valid) begin
                if (q_rsp.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    rsp_t e;
                    e = q_rsp.pop_front();
                    chk("rsp_data", {16'd0, rsp_rdata}, {16'd0, e.d});
                    chk("rsp_cycle", cyc, e.due);
                end
            end else if (q_rsp.size() != 0 && cyc >= q_rsp[0].due) begin
                chk("rsp_missing", 32'd0, 32'd1);
                void'(q_rsp.pop_front());
            end

            if (ready_due >= 0) begin
                if (cyc < ready_due) begin
                    chk("ready_busy", {31'd0, req_ready}, 32'd0);
                end else begin
                    chk("ready_return", {31'd0, req_ready}, 32'd1);
                    ready_due = -1;
                end
            end

            if (!sram_ce_n) begin
                ce_cnt++;
                if (!sram_we_n) we_cnt++;
                if (!sram_oe_n) oe_cnt++;
                chk("sram_a", {14'd0, sram_a}, {14'd0, cur.a});
                chk("lb_n", {31'd0, sram_lb_n}, {31'd0, ~cur.be[0]});
                chk("ub_n", {31'd0, sram_ub_n}, {31'd0, ~cur.be[1]});
                chk("dq_oe", {31'd0, sram_dq_oe}, {31'd0, cur.we});
                if (!sram_we_n) chk("dq_o", {16'd0, sram_dq_o}, {16'd0, cur.d});
            end else if (ce_cnt > 0) begin
                chk("ce_low_cycles", ce_cnt, cur.we ? WRC + 2 : RDC);
                chk("we_low_cycles", we_cnt, cur.we ? WRC : 0);
                chk("oe_low_cycles", oe_cnt, cur.we ? 0 : RDC);
                ce_cnt = 0; we_cnt = 0; oe_cnt = 0;
            end

            if (req_valid && req_ready) begin
                int t0;
                t0 = cyc + 1;
                cur.we = req_we; cur.a = req_addr; cur.d = req_wdata; cur.be = req_be;
                if (req_we) begin
                    if (req_be[0]) mdl[req_addr][7:0]  = req_wdata[7:0];
                    if (req_be[1]) mdl[req_addr][15:8] = req_wdata[15:8];
                    ready_due = t0 + WRC + 2;
                end else begin
                    rsp_t e;
                    e.d   = mdl[req_addr] & {{8{req_be[1]}}, {8{req_be[0]}}};
                    e.due = t0 + RDC;
                    q_rsp.push_back(e);
                    ready_due = t0 + RDC + 2;
                end
            end
        end
    end

    // Drivers: called and return at posedge+1; valid is left high so the next call is back-to-back.
    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        int n;
        n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(output logic [DW-1:0] d);
        int n;
        n = 0;
        d = '0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
        else d = rsp_rdata;
        @(posedge clk); #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0]    be;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [DW-1:0] rd;
        logic [AW-1:0] ra;

        vecs[0]  = '{1'b1, 18'h3FFFF, 16'hA2B3, 2'b11, 16'h0000};
        vecs[1]  = '{1'b0, 18'h3FFFF, 16'h0000, 2'b11, 16'hA2B3};
        vecs[2]  = '{1'b1, 18'h00010, 16'hFFFF, 2'b11, 16'h0000};
        vecs[3]  = '{1'b1, 18'h00010, 16'h55AA, 2'b01, 16'h0000};
        vecs[4]  = '{1'b0, 18'h00010, 16'h0000, 2'b11, 16'hFFAA};
        vecs[5]  = '{1'b0, 18'h00010, 16'h0000, 2'b10, 16'hFF00};
        vecs[6]  = '{1'b0, 18'h00010, 16'h0000, 2'b01, 16'h00AA};
        vecs[7]  = '{1'b1, 18'h00020, 16'h0F0F, 2'b11, 16'h0000};
        vecs[8]  = '{1'b1, 18'h00020, 16'h1234, 2'b00, 16'h0000};
        vecs[9]  = '{1'b0, 18'h00020, 16'h0000, 2'b11, 16'h0F0F};
        vecs[10] = '{1'b0, 18'h00020, 16'h0000, 2'b00, 16'h0000};
        vecs[11] = '{1'b1, 18'h20000, 16'hC3C3, 2'b10, 16'h0000};

        // Reset held three cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state",
            {21'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe, req_ready, rsp_valid, 3'd0},
            {21'd0, 5'b11111, 3'b000, 3'd0});
        chk("reset_data", {rsp_rdata, sram_dq_o}, 32'd0);
        chk("reset_addr", {14'd0, sram_a}, 32'd0);
        rst = 1'b0;
        chk("ready_low_at_release", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("ready_after_release", {31'd0, req_ready}, 32'd1);

        // Directed vectors, one transaction at a time.
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].be);
            req_valid = 1'b0;
            if (vecs[i].we) begin
                wait_ready();
            end else begin
                wait_rsp(rd);
                chk($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp});
            end
        end

        // Back-to-back read then write, valid held continuously.
        send(1'b0, 18'h3FFFF, 16'h0000, 2'b11);
        send(1'b1, 18'h3FFFE, 16'hBEEF, 2'b11);
        send(1'b0, 18'h3FFFE, 16'h0000, 2'b11);
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Seed the random address pool, then 1000 random back-to-back operations.
        for (int i = 0; i < 16; i++) begin
            ra = (i < 8) ? AW'(i) : AW'(18'h3FFF0 + i);
            send(1'b1, ra, 16'($urandom), 2'b11);
        end
        for (int i = 0; i < 1000; i++) begin
            int idx;
            idx = $urandom_range(0, 15);
            ra  = (idx < 8) ? AW'(idx) : AW'(18'h3FFF0 + idx);
            send(1'($urandom_range(0, 1)), ra, 16'($urandom), 2'($urandom_range(0, 3)));
        end
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_drained", q_rsp.size(), 32'd0);

        // Reset during the write pulse aborts the write.
        send(1'b1, 18'h00100, 16'h9999, 2'b11);
        req_valid = 1'b0;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (sram_we_n && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("we_pulse_seen", {31'd0, sram_we_n}, 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("abort_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("abort_ce_n", {31'd0, sram_ce_n}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ready();

        // Reset during a read suppresses its response.
        send(1'b0, 18'h3FFFE, 16'h0000, 2'b11);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", {31'd0, rsp_valid}, 32'd0);
            if (i == 1) rst = 1'b0;
        end
        @(posedge clk); #1;

        // A read after the aborts still works.
        send(1'b0, 18'h3FFFE, 16'h0000, 2'b11);
        req_valid = 1'b0;
        wait_rsp(rd);
        chk("read_after_reset", {16'd0, rd}, {16'd0, mdl[18'h3FFFE]});
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
